// File: rtl/countdown_timer.sv
// Loadable down counter with valid/ready load, one-cycle done pulse and clear.
// Optional: define COUNTDOWN_AUTO_RELOAD_EN to restart from the loaded value on each expiry.
module countdown_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_fire;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  assign load_ready = (state_q == IDLE) && !clear;
  assign load_fire  = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_fire) begin
            cnt_d = load_value;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_d = load_value;
`endif
            if (load_value != '0) begin
              state_d = COUNT;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        COUNT: begin
          if (enable) begin
            if (cnt_q == WIDTH'(1)) begin
              done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              // Zero loads never reach COUNT, so reload_q is always nonzero here.
              cnt_d = reload_q;
`else
              cnt_d   = '0;
              state_d = DONE;
`endif
            end else begin
              cnt_d = cnt_q - WIDTH'(1);
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d == COUNT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign q    = cnt_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
